// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, the x0 index and sequencer state encoding for register file access
package rf_pkg;
    localparam int XLEN = 64;
    localparam int REG_IDX_W = 5;
    localparam int unsigned REG_ZERO = 0;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ1 = 3'd2,
        READ2 = 3'd3,
        RESP  = 3'd4
    } state_t;
endpackage

// File: rtl/regfile_access_sequencer.sv
// regfile_access_sequencer: serialises operand reads and writebacks onto a single-port register file
module regfile_access_sequencer #(
    parameter int XLEN = rf_pkg::XLEN,
    parameter int REG_IDX_W = rf_pkg::REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [REG_IDX_W-1:0] rd_req_rs1,
    input  logic [REG_IDX_W-1:0] rd_req_rs2,
    output logic                 rd_rsp_valid,
    input  logic                 rd_rsp_ready,
    output logic [XLEN-1:0]      rd_rsp_rs1_data,
    output logic [XLEN-1:0]      rd_rsp_rs2_data,
    input  logic                 wr_req_valid,
    output logic                 wr_req_ready,
    input  logic [REG_IDX_W-1:0] wr_req_rd,
    input  logic [XLEN-1:0]      wr_req_data,
    output logic [REG_IDX_W-1:0] rf_reg_num,
    output logic                 rf_write,
    output logic [XLEN-1:0]      rf_data_in,
    input  logic [XLEN-1:0]      rf_data_out
);
    import rf_pkg::*;

    localparam logic [REG_IDX_W-1:0] ZERO_IDX = REG_IDX_W'(REG_ZERO);

    state_t state;
    logic [REG_IDX_W-1:0] rs2_idx;

    // Requests are only taken in IDLE; a pending write shadows a simultaneous read
    always_comb begin
        wr_req_ready = state == IDLE;
        rd_req_ready = state == IDLE && !wr_req_valid;
    end

    // Port sequencing: rf_reg_num is loaded one cycle ahead so each READ/WRITE cycle sees its index
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            rf_write        <= 1'b0;
            rf_reg_num      <= '0;
            rf_data_in      <= '0;
            rs2_idx         <= '0;
            rd_rsp_valid    <= 1'b0;
            rd_rsp_rs1_data <= '0;
            rd_rsp_rs2_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_req_valid) begin
                        rf_reg_num <= wr_req_rd;
                        rf_data_in <= wr_req_data;
                        rf_write   <= wr_req_rd != ZERO_IDX;
                        state      <= WRITE;
                    end else if (rd_req_valid) begin
                        rf_reg_num <= rd_req_rs1;
                        rs2_idx    <= rd_req_rs2;
                        state      <= READ1;
                    end
                end
                WRITE: begin
                    rf_write   <= 1'b0;
                    rf_data_in <= '0;
                    state      <= IDLE;
                end
                READ1: begin
                    rd_rsp_rs1_data <= rf_reg_num == ZERO_IDX ? '0 : rf_data_out;
                    rf_reg_num      <= rs2_idx;
                    state           <= READ2;
                end
                READ2: begin
                    rd_rsp_rs2_data <= rf_reg_num == ZERO_IDX ? '0 : rf_data_out;
                    rd_rsp_valid    <= 1'b1;
                    state           <= RESP;
                end
                RESP: begin
                    if (rd_rsp_ready) begin
                        rd_rsp_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_access_sequencer.sv
// tb_regfile_access_sequencer: scoreboard bench with a behavioural single-port register file
module tb_regfile_access_sequencer;
    import rf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 resetn = 1'b0;
    logic                 rd_req_valid = 1'b0;
    logic                 rd_req_ready;
    logic [REG_IDX_W-1:0] rd_req_rs1 = '0;
    logic [REG_IDX_W-1:0] rd_req_rs2 = '0;
    logic                 rd_rsp_valid;
    logic                 rd_rsp_ready = 1'b0;
    logic [XLEN-1:0]      rd_rsp_rs1_data;
    logic [XLEN-1:0]      rd_rsp_rs2_data;
    logic                 wr_req_valid = 1'b0;
    logic                 wr_req_ready;
    logic [REG_IDX_W-1:0] wr_req_rd = '0;
    logic [XLEN-1:0]      wr_req_data = '0;
    logic [REG_IDX_W-1:0] rf_reg_num;
    logic                 rf_write;
    logic [XLEN-1:0]      rf_data_in;
    logic [XLEN-1:0]      rf_data_out;

    regfile_access_sequencer dut (
        .clk(clk), .resetn(resetn),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_rs1(rd_req_rs1), .rd_req_rs2(rd_req_rs2),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rd_rsp_rs1_data(rd_rsp_rs1_data), .rd_rsp_rs2_data(rd_rsp_rs2_data),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_rd(wr_req_rd), .wr_req_data(wr_req_data),
        .rf_reg_num(rf_reg_num), .rf_write(rf_write),
        .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
    );

    // Behavioural register file; slot 0 holds garbage so the sequencer must mask x0 itself
    logic [XLEN-1:0] mem [32];
    logic [XLEN-1:0] model [32];
    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            model[i] = '0;
        end
        mem[0] = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    assign rf_data_out = mem[rf_reg_num];
    always @(posedge clk) if (rf_write) mem[rf_reg_num] <= rf_data_in;

    int wr_pulses = 0;
    int x0_writes = 0;
    always @(posedge clk) begin
        if (rf_write) wr_pulses <= wr_pulses + 1;
        if (rf_write && rf_reg_num == '0) x0_writes <= x0_writes + 1;
    end

    int errors = 0;
    int checks = 0;
    logic [2*XLEN-1:0] sb [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] rd, input logic [63:0] d);
        int n;
        @(negedge clk);
        wr_req_valid = 1'b1;
        wr_req_rd = rd;
        wr_req_data = d;
        #1;
        n = 0;
        while (!wr_req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!wr_req_ready) begin
            check("wr_timeout", 0, 1);
            wr_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (rd != 0) model[rd] = d;
        @(negedge clk);
        wr_req_valid = 1'b0;
        check("wr_en", 64'(rf_write), 64'(rd != 0));
        check("wr_num", 64'(rf_reg_num), 64'(rd));
        check("wr_data", rf_data_in, d);
        check("wr_busy", {62'd0, wr_req_ready, rd_req_ready}, 0);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b, input int hold);
        int n;
        logic [63:0] e1, e2, s1, s2;
        logic [127:0] e;
        @(negedge clk);
        rd_req_valid = 1'b1;
        rd_req_rs1 = a;
        rd_req_rs2 = b;
        #1;
        n = 0;
        while (!rd_req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rd_req_ready) begin
            check("rd_timeout", 0, 1);
            rd_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e1 = (a == 0) ? 64'd0 : model[a];
        e2 = (b == 0) ? 64'd0 : model[b];
        sb.push_back({e1, e2});
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) rd_req_valid = 1'b0;
        end while (!rd_rsp_valid && n < 20);
        check("rsp_latency", 64'(n), 3);
        if (!rd_rsp_valid) return;
        s1 = rd_rsp_rs1_data;
        s2 = rd_rsp_rs2_data;
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", 64'(rd_rsp_valid), 1);
            check("hold_rs1", rd_rsp_rs1_data, s1);
            check("hold_rs2", rd_rsp_rs2_data, s2);
            check("hold_rdy", {62'd0, wr_req_ready, rd_req_ready}, 0);
        end
        rd_rsp_ready = 1'b1;
        e = sb.pop_front();
        check("rs1_data", rd_rsp_rs1_data, e[127:64]);
        check("rs2_data", rd_rsp_rs2_data, e[63:0]);
        @(posedge clk);
        @(negedge clk);
        rd_rsp_ready = 1'b0;
        check("rsp_drop", 64'(rd_rsp_valid), 0);
        check("idle_rdy", 64'(wr_req_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        check("rst_valid", 64'(rd_rsp_valid), 0);
        check("rst_write", 64'(rf_write), 0);
        check("rst_num", 64'(rf_reg_num), 0);
        check("rst_din", rf_data_in, 0);
        check("rst_rs1", rd_rsp_rs1_data, 0);
        check("rst_rs2", rd_rsp_rs2_data, 0);
        check("rst_wrdy", 64'(wr_req_ready), 1);

        do_read(5'd5, 5'd6, 0);
        check("no_writes", 64'(wr_pulses), 0);

        do_write(5'd5, 64'hDEAD_BEEF_0123_4567);
        do_read(5'd5, 5'd0, 0);

        do_write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        do_read(5'd0, 5'd0, 0);

        @(negedge clk);
        wr_req_valid = 1'b1;
        wr_req_rd = 5'd7;
        wr_req_data = 64'h42;
        rd_req_valid = 1'b1;
        rd_req_rs1 = 5'd7;
        rd_req_rs2 = 5'd7;
        #1;
        check("both_rd_rdy", 64'(rd_req_ready), 0);
        check("both_wr_rdy", 64'(wr_req_ready), 1);
        @(posedge clk);
        model[7] = 64'h42;
        @(negedge clk);
        wr_req_valid = 1'b0;
        check("both_wr_en", 64'(rf_write), 1);
        check("both_rd_wait", 64'(rd_req_ready), 0);
        do_read(5'd7, 5'd7, 0);

        do_read(5'd5, 5'd7, 5);

        for (int i = 0; i < 6; i++) begin
            do_write(5'($urandom_range(0, 31)), {$urandom, $urandom});
            do_read(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), i % 2);
        end

        @(negedge clk);
        rd_req_valid = 1'b1;
        rd_req_rs1 = 5'd5;
        rd_req_rs2 = 5'd7;
        #1;
        n = 0;
        while (!rd_req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("r6_accept", 64'(rd_req_ready), 1);
        @(posedge clk);
        @(negedge clk);
        rd_req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        check("r6_valid", 64'(rd_rsp_valid), 0);
        check("r6_write", 64'(rf_write), 0);
        check("r6_rs1", rd_rsp_rs1_data, 0);
        check("r6_rs2", rd_rsp_rs2_data, 0);
        check("r6_idle", 64'(wr_req_ready), 1);
        check("r6_num", 64'(rf_reg_num), 0);
        repeat (3) begin
            @(negedge clk);
            check("r6_no_rsp", 64'(rd_rsp_valid), 0);
        end

        check("x0_writes", 64'(x0_writes), 0);
        check("sb_empty", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
